btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter STABLE, default 1000: consecutive synchronized cycles a new button level must persist before it is accepted; legal range 1 to 2^CW-1.
REQ-002 Parameter DELAY, default 20000: cycles from an accepted press to the first auto-repeat strobe; legal range 1 to 2^CW-1.
REQ-003 Parameter RATE, default 5000: cycles between subsequent auto-repeat strobes; legal range 1 to 2^CW-1.
REQ-004 Parameter CW, default 16: width of the debounce and repeat counters.
REQ-005 clk  input  1  master clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 button_n  input  1  raw, asynchronous, active-low pushbutton; bouncy.
REQ-008 level_n  output  1  debounced active-low button level; drives any active-low button trigger directly.
REQ-009 press  output  1  one-cycle strobe on an accepted press.
REQ-010 release  output  1  one-cycle strobe on an accepted release.
REQ-011 rpt  output  1  one-cycle auto-repeat strobe while the button is held.

Function
REQ-012 button_n SHALL pass through a 2-flop synchronizer; the FSM and counters SHALL see only the second flop.
REQ-013 FSM states SHALL be UP (released), UP_CHK (press candidate), DN (held) and DN_CHK (release candidate).
REQ-014 UP: synchronized low -> UP_CHK, debounce count starts; synchronized high -> stay.
REQ-015 UP_CHK: any synchronized high -> UP, with no output change.
REQ-016 UP_CHK: low for STABLE consecutive cycles -> DN.
REQ-017 Entry to DN from UP_CHK: level_n=0 and press=1 SHALL appear together on exactly the edge e0+STABLE+2, where e0 is the first edge sampling button_n low with no bounce.
REQ-018 DN: synchronized high -> DN_CHK; synchronized low -> stay.
REQ-019 DN_CHK: any synchronized low -> DN, with no output and the repeat count undisturbed.
REQ-020 DN_CHK: high for STABLE consecutive cycles -> UP; level_n=1 and release=1 SHALL appear together; latency is symmetric with REQ-017.
REQ-021 rpt SHALL assert in the same cycle as press.
REQ-022 rpt SHALL assert again DELAY cycles after press, then every RATE cycles, for as long as level_n=0, including while in DN_CHK.
REQ-023 If a repeat falls due on the cycle a release is accepted, release SHALL assert and rpt SHALL be suppressed.
REQ-024 No rpt SHALL assert while level_n=1.
REQ-025 The repeat counter SHALL clear on release acceptance; the next press restarts the DELAY phase.
REQ-026 press, release and rpt SHALL be registered and each high for exactly one cycle per event; press and release SHALL never assert in the same cycle.
REQ-027 Counters SHALL saturate or clear, never wrap.
REQ-028 A candidate interrupted at count STABLE-1 SHALL restart from zero on the next candidate.

Reset
REQ-029 While reset=1 at an edge: synchronizer flops=1, state=UP, all counters=0, level_n=1, press=release=rpt=0.
REQ-030 Reset asserted mid-hold (DN or DN_CHK) SHALL force level_n=1 with no release strobe.
REQ-031 After reset deasserts with button_n still low, a fresh press SHALL follow per REQ-017.
REQ-032 Reset SHALL take priority over all FSM transitions in the same cycle.

Verification (STABLE=4, DELAY=10, RATE=3, CW=8)
REQ-033 Scenario 1: reset, button_n=1 for 50 cycles -> level_n=1, press/release/rpt never high.
REQ-034 Scenario 2: button_n low from e0, held -> press and rpt at e6; level_n=0 from e6; further rpt at e16, e19, e22, e25.
REQ-035 Scenario 3: bounce, button_n low 3 cycles, high 1, low 3, high -> no press; level_n stays 1.
REQ-036 Scenario 4: after a hold, button_n high 2 cycles then low -> no release, repeat cadence unchanged; button_n high held from edge r0 -> release at r0+6, level_n=1, no rpt afterwards.
REQ-037 Scenario 5: reset pulsed for 1 cycle during a hold with button_n low -> level_n=1, no release; press reasserts 6 edges after the first post-reset edge sampling low.
REQ-038 Scenario 6: release timed so acceptance coincides with a due repeat -> release=1, rpt=0 that cycle and thereafter.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw active-low pushbutton, debounces it with a
// four-state FSM and produces press, release and auto-repeat strobes.
// The release strobe port is named rel because "release" is a reserved word
// in SystemVerilog.
module btn_debounce #(
  parameter int STABLE = 1000,
  parameter int DELAY  = 20000,
  parameter int RATE   = 5000,
  parameter int CW     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic level_n,
  output logic press,
  output logic rel,
  output logic rpt
);

  typedef enum logic [1:0] {
    UP     = 2'd0,
    UP_CHK = 2'd1,
    DN     = 2'd2,
    DN_CHK = 2'd3
  } state_t;

  // Terminal counts; a counter equal to these has seen the full interval.
  localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE - 1);
  localparam logic [CW-1:0] DELAY_M1  = CW'(DELAY - 1);
  localparam logic [CW-1:0] RATE_M1   = CW'(RATE - 1);

  logic [1:0]    sync_reg;
  logic          sync_n;

  state_t        state_reg, state_next;
  logic [CW-1:0] db_cnt_reg, db_cnt_next;
  logic [CW-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic          rpt_phase_reg, rpt_phase_next;   // 0: waiting DELAY, 1: RATE
  logic          level_n_reg, level_n_next;
  logic          press_reg, press_next;
  logic          rel_reg, rel_next;
  logic          rpt_reg, rpt_next;
  logic          rel_accept;
  logic [CW-1:0] rpt_limit_m1;

  // Two-flop synchronizer chain; idles high so reset never looks like a press.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      // First stage samples the asynchronous pin.
      always_ff @(posedge clk) begin
        if (reset) sync_reg[gi] <= 1'b1;
        else       sync_reg[gi] <= button_n;
      end
    end else begin : g_rest
      // Later stages just shift the sampled level along.
      always_ff @(posedge clk) begin
        if (reset) sync_reg[gi] <= 1'b1;
        else       sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign sync_n       = sync_reg[1];
  assign rpt_limit_m1 = rpt_phase_reg ? RATE_M1 : DELAY_M1;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= UP;
      db_cnt_reg    <= '0;
      rpt_cnt_reg   <= '0;
      rpt_phase_reg <= 1'b0;
      level_n_reg   <= 1'b1;
      press_reg     <= 1'b0;
      rel_reg       <= 1'b0;
      rpt_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      db_cnt_reg    <= db_cnt_next;
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_phase_reg <= rpt_phase_next;
      level_n_reg   <= level_n_next;
      press_reg     <= press_next;
      rel_reg       <= rel_next;
      rpt_reg       <= rpt_next;
    end
  end

  // Next-state logic: debounce FSM first, then the auto-repeat timer.
  always_comb begin
    state_next     = state_reg;
    db_cnt_next    = db_cnt_reg;
    rpt_cnt_next   = rpt_cnt_reg;
    rpt_phase_next = rpt_phase_reg;
    level_n_next   = level_n_reg;
    press_next     = 1'b0;
    rel_next       = 1'b0;
    rpt_next       = 1'b0;
    rel_accept     = 1'b0;

    case (state_reg)
      UP: begin
        if (!sync_n) begin
          state_next  = UP_CHK;
          db_cnt_next = '0;
        end
      end
      UP_CHK: begin
        if (sync_n) begin
          // Bounce: drop the candidate so the next one starts from zero.
          state_next  = UP;
          db_cnt_next = '0;
        end else if (db_cnt_reg == STABLE_M1) begin
          state_next     = DN;
          db_cnt_next    = '0;
          level_n_next   = 1'b0;
          press_next     = 1'b1;
          rpt_next       = 1'b1;   // first repeat coincides with the press
          rpt_cnt_next   = '0;
          rpt_phase_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      DN: begin
        if (sync_n) begin
          state_next  = DN_CHK;
          db_cnt_next = '0;
        end
      end
      DN_CHK: begin
        if (!sync_n) begin
          state_next  = DN;
          db_cnt_next = '0;
        end else if (db_cnt_reg == STABLE_M1) begin
          state_next     = UP;
          db_cnt_next    = '0;
          level_n_next   = 1'b1;
          rel_next       = 1'b1;
          rel_accept     = 1'b1;
          rpt_cnt_next   = '0;
          rpt_phase_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next  = UP;
        db_cnt_next = '0;
      end
    endcase

    // The repeat timer runs for the whole held period, including release
    // candidates, but a release being accepted this cycle wins over a repeat.
    if (!level_n_reg && !rel_accept &&
        (state_reg == DN || state_reg == DN_CHK)) begin
      if (rpt_cnt_reg == rpt_limit_m1) begin
        rpt_next       = 1'b1;
        rpt_cnt_next   = '0;
        rpt_phase_next = 1'b1;
      end else begin
        rpt_cnt_next = rpt_cnt_reg + 1'b1;
      end
    end
  end

  assign level_n = level_n_reg;
  assign press   = press_reg;
  assign rel     = rel_reg;
  assign rpt     = rpt_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE=4, DELAY=10, RATE=3, CW=8.
// Edge k of a scenario is the k-th rising edge after the scenario's first
// stimulus change; outputs are sampled 1 time unit after each edge.
module tb_btn_debounce;

  logic clk;
  logic reset;
  logic button_n;
  logic level_n;
  logic press;
  logic rel;
  logic rpt;

  int checks;
  int errors;

  btn_debounce #(
    .STABLE(4),
    .DELAY (10),
    .RATE  (3),
    .CW    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .button_n(button_n),
    .level_n (level_n),
    .press   (press),
    .rel     (rel),
    .rpt     (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and move to the sampling point just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check all four outputs against the expected values for edge k.
  task automatic check_all(input string scen, input int k, input logic e_lvl,
                           input logic e_press, input logic e_rel, input logic e_rpt);
    check($sformatf("%s_level_n_e%0d", scen, k), level_n, e_lvl);
    check($sformatf("%s_press_e%0d", scen, k), press, e_press);
    check($sformatf("%s_release_e%0d", scen, k), rel, e_rel);
    check($sformatf("%s_rpt_e%0d", scen, k), rpt, e_rpt);
  endtask

  initial begin
    int strobes;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    button_n = 1'b1;

    // Reset state.
    for (int i = 0; i < 3; i++) step();
    check_all("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    $display("reset: checked idle outputs under reset");

    // Scenario 1: idle high for 50 cycles.
    strobes = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (press || rel || rpt || !level_n) strobes++;
    end
    check("s1_idle_activity", (strobes == 0), 1'b1);
    $display("s1: idle 50 cycles, activity count %0d", strobes);

    // Scenarios 2, 4 and 6: press at e6, repeats at e16 + 3n, a 2-cycle
    // release bounce at e27..e28, then a release held from r0=e34 that is
    // accepted at e40, exactly where a repeat falls due.
    for (int k = 0; k <= 50; k++) begin
      logic e_lvl, e_press, e_rel, e_rpt;
      if (k < 27)      button_n = 1'b0;
      else if (k < 29) button_n = 1'b1;
      else if (k < 34) button_n = 1'b0;
      else             button_n = 1'b1;
      step();
      e_press = (k == 6);
      e_rel   = (k == 40);
      e_lvl   = !(k >= 6 && k < 40);
      e_rpt   = (k == 6) || (k >= 16 && k < 40 && ((k - 16) % 3 == 0));
      check_all("s246", k, e_lvl, e_press, e_rel, e_rpt);
    end
    $display("s2/s4/s6: hold, bounce, release coinciding with repeat");

    // Scenario 3: low 3, high 1, low 3, then high: never accepted.
    for (int k = 0; k < 16; k++) begin
      button_n = !((k < 3) || (k >= 4 && k < 7));
      step();
      check_all("s3", k, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    $display("s3: bouncy press rejected");

    // Scenario 5: press at e6, one-cycle reset at e12 while held, fresh
    // press at e19 (first low sample after reset is e13), repeats at e29
    // and e32, e35, e38, then a release from r0=e34 accepted at e40 that
    // does not coincide with a repeat (next would be e41).
    for (int k = 0; k <= 45; k++) begin
      logic e_lvl, e_press, e_rel, e_rpt;
      button_n = (k >= 34);
      reset    = (k == 12);
      step();
      e_press = (k == 6) || (k == 19);
      e_rel   = (k == 40);
      e_lvl   = !((k >= 6 && k < 12) || (k >= 19 && k < 40));
      e_rpt   = (k == 6) || (k == 19) || (k == 29) || (k == 32) ||
                (k == 35) || (k == 38);
      check_all("s5", k, e_lvl, e_press, e_rel, e_rpt);
    end
    reset = 1'b0;
    $display("s5: reset mid-hold, re-press, plain release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
